// File: rtl/fb_writer.sv
// Framebuffer writer: buffers incoming fragments in a small FIFO, writes
// in-range fragments into an on-chip color memory, supports a full-buffer
// clear (after draining pending fragments) and an independent readback port.
module fb_writer #(
  parameter int FB_WIDTH_LOG2  = 7,
  parameter int FB_HEIGHT_LOG2 = 7,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [10:0]                           frag_x,
  input  logic [10:0]                           frag_y,
  input  logic [15:0]                           frag_color,
  input  logic                                  frag_valid,
  output logic                                  frag_ready,
  input  logic                                  clear_start,
  input  logic [15:0]                           clear_color,
  output logic                                  clearing,
  input  logic [FB_WIDTH_LOG2+FB_HEIGHT_LOG2-1:0] rd_addr,
  input  logic                                  rd_en,
  output logic [15:0]                           rd_data,
  output logic                                  rd_valid,
  output logic [31:0]                           frags_written,
  output logic [31:0]                           frags_dropped,
  output logic                                  busy
);

  localparam int ADDR_W = FB_WIDTH_LOG2 + FB_HEIGHT_LOG2;
  localparam int NPIX   = 1 << ADDR_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // FIFO entry: {in_range, pixel address, color}
  localparam int ENT_W  = 1 + ADDR_W + 16;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  // Range test is done once at push time so the pop path only sees a flag.
  function automatic logic frag_in_range(input logic [10:0] x, input logic [10:0] y);
    return (32'(x) < (32'd1 << FB_WIDTH_LOG2)) && (32'(y) < (32'd1 << FB_HEIGHT_LOG2));
  endfunction

  state_t             state;
  logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic               push;
  logic               pop;
  logic [ADDR_W-1:0]  frag_addr;
  logic               head_ok;
  logic [ADDR_W-1:0]  head_addr;
  logic [15:0]        head_color;
  logic [ADDR_W-1:0]  clr_addr;
  logic [15:0]        clr_color;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [15:0]        mem_wdata;
  logic [15:0]        color_mem [NPIX];

  assign frag_addr  = {frag_y[FB_HEIGHT_LOG2-1:0], frag_x[FB_WIDTH_LOG2-1:0]};
  assign frag_ready = (count < CNT_W'(FIFO_DEPTH)) && (state == IDLE);
  assign push       = frag_valid && frag_ready;
  assign pop        = (count != '0) && ((state == IDLE) || (state == DRAIN));
  assign {head_ok, head_addr, head_color} = fifo_mem[rd_ptr];
  assign busy       = (count != '0) || clearing;

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (!push && pop)
      count_nxt = count - 1'b1;
  end

  // FIFO payload storage (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {frag_in_range(frag_x, frag_y), frag_addr, frag_color};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  // Memory write-port arbitration: clearing owns the port, otherwise the FIFO head.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = head_addr;
    mem_wdata = head_color;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = clr_color;
    end else if (pop && head_ok) begin
      mem_we    = 1'b1;
    end
  end

  // Color memory write port.
  always_ff @(posedge clk) begin
    if (mem_we)
      color_mem[mem_waddr] <= mem_wdata;
  end

  // Readback port: registered read, old data on a same-edge write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= color_mem[rd_addr];
    end
  end

  // Fragment statistics, stepped at each pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frags_written <= '0;
      frags_dropped <= '0;
    end else if (pop) begin
      if (head_ok)
        frags_written <= frags_written + 32'd1;
      else
        frags_dropped <= frags_dropped + 32'd1;
    end
  end

  // Clear color is latched only when a clear is actually accepted.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && clear_start)
      clr_color <= clear_color;
  end

  // Control FSM: IDLE -> (DRAIN ->) CLEAR -> IDLE, with registered clearing flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clearing <= 1'b0;
      clr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            clearing <= 1'b1;
            clr_addr <= '0;
            // Anything still queued after this edge must be written first.
            state    <= (count_nxt != '0) ? DRAIN : CLEAR;
          end
        end
        DRAIN: begin
          if (count_nxt == '0)
            state <= CLEAR;
        end
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            state    <= IDLE;
            clearing <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Directed testbench for fb_writer with default parameters (128x128, FIFO 4).
module tb_fb_writer;

  localparam int NPIX = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] frag_x;
  logic [10:0] frag_y;
  logic [15:0] frag_color;
  logic        frag_valid;
  logic        frag_ready;
  logic        clear_start;
  logic [15:0] clear_color;
  logic        clearing;
  logic [13:0] rd_addr;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [31:0] frags_written;
  logic [31:0] frags_dropped;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  fb_writer dut (
    .clk           (clk),
    .rst           (rst),
    .frag_x        (frag_x),
    .frag_y        (frag_y),
    .frag_color    (frag_color),
    .frag_valid    (frag_valid),
    .frag_ready    (frag_ready),
    .clear_start   (clear_start),
    .clear_color   (clear_color),
    .clearing      (clearing),
    .rd_addr       (rd_addr),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .frags_written (frags_written),
    .frags_dropped (frags_dropped),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_frag(input logic [10:0] x, input logic [10:0] y, input logic [15:0] c);
    frag_x     = x;
    frag_y     = y;
    frag_color = c;
    frag_valid = 1'b1;
  endtask

  task automatic send_frag(input logic [10:0] x, input logic [10:0] y, input logic [15:0] c);
    set_frag(x, y, c);
    tick();
    frag_valid = 1'b0;
  endtask

  task automatic check_px(input string tag, input logic [13:0] a, input logic [15:0] exp);
    rd_addr = a;
    rd_en   = 1'b1;
    tick();
    rd_en   = 1'b0;
    check(tag, {15'd0, rd_valid, rd_data}, {16'h0001, exp});
  endtask

  task automatic wait_clear(output int cycles);
    cycles = 0;
    while (clearing && cycles < 20000) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    int cyc;
    int bad;
    logic [15:0] held;

    rst = 1'b1; frag_x = '0; frag_y = '0; frag_color = '0; frag_valid = 1'b0;
    clear_start = 1'b0; clear_color = '0; rd_addr = '0; rd_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_frag_ready", {31'd0, frag_ready}, 32'd1);
    check("rst_clearing",   {31'd0, clearing},   32'd0);
    check("rst_rd_valid",   {31'd0, rd_valid},   32'd0);
    check("rst_rd_data",    {16'd0, rd_data},    32'd0);
    check("rst_written",    frags_written,       32'd0);
    check("rst_dropped",    frags_dropped,       32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);

    // Full clear with 0x001F; a second clear_start mid-clear must be ignored
    clear_start = 1'b1; clear_color = 16'h001F;
    tick();
    clear_start = 1'b0;
    check("clr_ready_low", {31'd0, frag_ready}, 32'd0);
    check("clr_busy",      {31'd0, busy},       32'd1);
    cyc = 0;
    while (clearing && cyc < 20000) begin
      cyc++;
      clear_start = (cyc == 100);
      clear_color = (cyc == 100) ? 16'hFFFF : 16'h001F;
      tick();
    end
    clear_start = 1'b0;
    check("clr_cycles", cyc, NPIX);
    check("clr_idle_busy", {31'd0, busy}, 32'd0);
    bad = 0;
    rd_en = 1'b1;
    for (int a = 0; a < NPIX; a++) begin
      rd_addr = 14'(a);
      tick();
      if (rd_data !== 16'h001F || rd_valid !== 1'b1) bad++;
    end
    rd_en = 1'b0;
    check("clr_fill_bad", bad, 0);

    // rd_valid drops and rd_data holds when rd_en is low
    held = rd_data;
    tick();
    check("rd_idle_valid", {31'd0, rd_valid}, 32'd0);
    check("rd_idle_hold",  {16'd0, rd_data},  {16'd0, held});

    // Single fragment (3,5) -> address 643, written one edge after acceptance
    send_frag(11'd3, 11'd5, 16'hF800);
    check("lat_before", frags_written, 32'd0);
    check("lat_busy",   {31'd0, busy}, 32'd1);
    tick();
    check("lat_written", frags_written, 32'd1);
    check_px("px_643", 14'd643, 16'hF800);

    // Back-to-back burst to distinct addresses, ready must stay high
    for (int i = 0; i < 4; i++) begin
      set_frag(11'(10 + i), 11'd1, 16'(16'h1111 * (i + 1)));
      check("burst_ready", {31'd0, frag_ready}, 32'd1);
      tick();
    end
    frag_valid = 1'b0;
    check("burst_busy_tail", {31'd0, busy}, 32'd1);
    tick();
    check("burst_busy_done", {31'd0, busy}, 32'd0);
    check("burst_written", frags_written, 32'd5);
    check_px("burst_138", 14'd138, 16'h1111);
    check_px("burst_139", 14'd139, 16'h2222);
    check_px("burst_140", 14'd140, 16'h3333);
    check_px("burst_141", 14'd141, 16'h4444);

    // Burst to one address: ordering means the last color wins
    set_frag(11'd20, 11'd2, 16'hAAAA); tick();
    set_frag(11'd20, 11'd2, 16'hBBBB); tick();
    set_frag(11'd20, 11'd2, 16'hCCCC); tick();
    set_frag(11'd20, 11'd2, 16'hDDDD); tick();
    frag_valid = 1'b0;
    tick();
    check("order_written", frags_written, 32'd9);
    check_px("order_276", 14'd276, 16'hDDDD);

    // Largest in-range coordinate
    send_frag(11'd127, 11'd127, 16'h07E0);
    tick();
    check_px("corner_16383", 14'd16383, 16'h07E0);

    // Read and write of the same address at the same edge returns old data
    send_frag(11'd3, 11'd5, 16'h0F0F);
    check_px("rdw_old", 14'd643, 16'hF800);
    check_px("rdw_new", 14'd643, 16'h0F0F);

    // Out-of-range fragments are dropped with no memory change
    send_frag(11'd128, 11'd0, 16'hABCD);
    send_frag(11'd0, 11'd200, 16'hABCD);
    tick();
    check("drop_count",   frags_dropped, 32'd2);
    check("drop_written", frags_written, 32'd11);
    check_px("drop_px0",    14'd0,    16'h001F);
    check_px("drop_px9216", 14'd9216, 16'h001F);

    // Three fragments then clear_start in the following cycle
    set_frag(11'd1, 11'd0,   16'h1234); tick();
    set_frag(11'd2, 11'd0,   16'h5678); tick();
    set_frag(11'd0, 11'd127, 16'h9ABC); tick();
    frag_valid = 1'b0;
    clear_start = 1'b1; clear_color = 16'h7C00;
    tick();
    clear_start = 1'b0;
    check("pre_clr_written", frags_written, 32'd14);
    check("pre_clr_clearing", {31'd0, clearing}, 32'd1);
    wait_clear(cyc);
    check("pre_clr_cycles", cyc, NPIX);
    check_px("pre_clr_px1",     14'd1,     16'h7C00);
    check_px("pre_clr_px2",     14'd2,     16'h7C00);
    check_px("pre_clr_px16256", 14'd16256, 16'h7C00);
    check_px("pre_clr_px643",   14'd643,   16'h7C00);

    // Asynchronous reset in the middle of a clear
    clear_start = 1'b1; clear_color = 16'h1234;
    tick();
    clear_start = 1'b0;
    repeat (50) tick();
    rd_addr = 14'd643; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("abort_pre_rd", {15'd0, rd_valid, rd_data}, {16'h0001, 16'h7C00});
    #2;
    rst = 1'b1;
    #1;
    check("abort_clearing", {31'd0, clearing},   32'd0);
    check("abort_busy",     {31'd0, busy},       32'd0);
    check("abort_rd_valid", {31'd0, rd_valid},   32'd0);
    check("abort_rd_data",  {16'd0, rd_data},    32'd0);
    check("abort_written",  frags_written,       32'd0);
    check("abort_dropped",  frags_dropped,       32'd0);
    check("abort_ready",    {31'd0, frag_ready}, 32'd1);
    rst = 1'b0;
    tick();
    check("abort_stays_idle", {31'd0, clearing}, 32'd0);

    // New clear after reset, arriving with a fragment still queued (drain path)
    set_frag(11'd5, 11'd5, 16'h0001); tick();
    set_frag(11'd6, 11'd5, 16'h0002); tick();
    set_frag(11'd7, 11'd5, 16'h0003);
    clear_start = 1'b1; clear_color = 16'h5555;
    tick();
    frag_valid = 1'b0; clear_start = 1'b0;
    check("drain_ready_low", {31'd0, frag_ready}, 32'd0);
    check("drain_written2",  frags_written, 32'd2);
    wait_clear(cyc);
    check("drain_cycles",   cyc, NPIX + 1);
    check("drain_written3", frags_written, 32'd3);
    check_px("drain_px645",   14'd645,   16'h5555);
    check_px("drain_px647",   14'd647,   16'h5555);
    check_px("drain_px0",     14'd0,     16'h5555);
    check_px("drain_px16383", 14'd16383, 16'h5555);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter FB_WIDTH_LOG2, default 7: framebuffer width is 2^FB_WIDTH_LOG2 pixels.
REQ-002 Parameter FB_HEIGHT_LOG2, default 7: framebuffer height is 2^FB_HEIGHT_LOG2 pixels.
REQ-003 Parameter FIFO_DEPTH, default 4: number of input fragment FIFO entries (power of two).
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port frag_x, input, 11: fragment pixel x, unsigned.
REQ-007 Port frag_y, input, 11: fragment pixel y, unsigned.
REQ-008 Port frag_color, input, 16: fragment color, rgb565_t.
REQ-009 Port frag_valid, input, 1: fragment offered.
REQ-010 Port frag_ready, output, 1: fragment accepted when frag_valid && frag_ready at a rising edge.
REQ-011 Port clear_start, input, 1: single-cycle request to fill the buffer with clear_color.
REQ-012 Port clear_color, input, 16: fill value, sampled in the clear_start cycle.
REQ-013 Port clearing, output, 1: drain or clear in progress.
REQ-014 Port rd_addr, input, FB_WIDTH_LOG2+FB_HEIGHT_LOG2: readback/scanout address, {y,x}.
REQ-015 Port rd_en, input, 1: readback request.
REQ-016 Port rd_data, output, 16: readback pixel.
REQ-017 Port rd_valid, output, 1: rd_data valid.
REQ-018 Port frags_written, output, 32: count of fragments written to memory.
REQ-019 Port frags_dropped, output, 32: count of out-of-range fragments discarded.
REQ-020 Port busy, output, 1: FIFO non-empty or clearing.

Function
REQ-021 Internal color memory: 2^(FB_WIDTH_LOG2+FB_HEIGHT_LOG2) x 16 bits, with one write port and one independent read port.
REQ-022 Pixel address {frag_y[FB_HEIGHT_LOG2-1:0], frag_x[FB_WIDTH_LOG2-1:0]}.
REQ-023 frag_ready = (FIFO count < FIFO_DEPTH) && state == IDLE; combinational, independent of frag_valid.
REQ-024 An accepted fragment is pushed into the FIFO; the head entry is popped and processed one per cycle while state is IDLE or DRAIN.
REQ-025 A popped fragment with frag_x >= 2^FB_WIDTH_LOG2 or frag_y >= 2^FB_HEIGHT_LOG2 is discarded, with no memory write; frags_dropped increments.
REQ-026 A popped in-range fragment is written at the pop edge; frags_written increments.
REQ-027 Latency: a fragment accepted at edge t with the FIFO empty is written at edge t+1.
REQ-028 Simultaneous push and pop with the FIFO full is not possible; frag_ready is low when full. Simultaneous push and pop at other counts leaves the count unchanged.
REQ-029 State machine IDLE -> DRAIN on clear_start when the FIFO is non-empty; IDLE -> CLEAR on clear_start when the FIFO is empty.
REQ-030 DRAIN: no pushes; pops continue; DRAIN -> CLEAR in the cycle after the last pop.
REQ-031 CLEAR: clear_color is written to address 0,1,...,N-1, one per cycle, with no fragment writes; CLEAR -> IDLE after address N-1 is written.
REQ-032 clearing is high from the edge after clear_start through the edge writing address N-1; it is low in IDLE.
REQ-033 clear_start is ignored outside IDLE.
REQ-034 Readback: rd_en at edge t gives rd_data = memory[rd_addr] and rd_valid=1 after edge t; otherwise rd_valid=0 and rd_data holds.
REQ-035 A read and a write to the same address at the same edge return the old data.
REQ-036 Counters wrap modulo 2^32.

Reset
REQ-037 On rst: state=IDLE, FIFO empty, frag_ready=1 after reset release, clearing=0, rd_valid=0, rd_data=0, frags_written=0, frags_dropped=0, busy=0.
REQ-038 Reset mid-DRAIN or mid-CLEAR aborts the operation immediately; memory contents are unspecified.

Verification
REQ-039 Clear with 0x001F, then read all addresses -> every rd_data=0x001F; clearing high for exactly 16384 cycles (default parameters).
REQ-040 Fragment (3,5,0xF800), then read address 643 two cycles later -> 0xF800; frags_written=1.
REQ-041 frag_valid held with frag_ready forced low by the test -> the FIFO fills at 4 and frag_ready drops; release -> 4 writes in order, with no loss or duplication.
REQ-042 Fragments (128,0) and (0,200) -> frags_dropped=2; no memory change.
REQ-043 Push 3 fragments, then clear_start in the next cycle -> DRAIN writes all 3 before CLEAR; the final read shows clear_color everywhere; frags_written=3.
REQ-044 Assert rst during CLEAR -> all outputs at reset values in the same cycle; a new clear_start is accepted after release.
